// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB requester arbiter: FSM state encoding and
// default parameter values used by apb_arbiter and its round-robin picker.
// No ports; imported by every file of the block.
package apb_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible requester after last_i, wrapping mod N.
// Latency: purely combinational. Backpressure: none, the caller decides when to use gnt_o.
// Ports: elig_i eligible mask, last_i index of previous winner, gnt_o one-hot winner, vld_o any winner.
module rr_pick
   import apb_arb_pkg::*;
#(
   parameter int N = DEF_NUM_REQ
) (
   input  logic [N-1:0]         elig_i,
   input  logic [$clog2(N)-1:0] last_i,
   output logic [N-1:0]         gnt_o,
   output logic                 vld_o
);

   logic [$clog2(N)-1:0] idx;

   // Walk last+1, last+2, ... last+N; the first eligible slot wins, which
   // gives the previous winner the lowest priority in this round.
   always_comb begin
      gnt_o = '0;
      vld_o = 1'b0;
      idx   = '0;
      for (int i = 1; i <= N; i++) begin
         idx = ($clog2(N))'((int'(last_i) + i) % N);
         if (!vld_o && elig_i[idx]) begin
            gnt_o[idx] = 1'b1;
            vld_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_arbiter.sv
// Arbitrates NUM_REQ requesters onto one APB master command port with round-robin fairness.
// Latency: req -> PTRANSFER 1 cycle; xfer_done -> req_done 1 cycle; next grant 2 cycles after xfer_done.
// Backpressure: one command in flight; requesters hold req until their req_done pulse (with timeout).
// Ports: PCLK/PRESET clock and sync reset; req/req_addr/req_wdata/req_write requester side;
//   req_gnt/req_done/req_err/req_rdata responses; PTRANSFER/ADDRESS/WRITE_EN/WRITE_DATA
//   command to the master; xfer_done/READ_DATA completion from the master; busy while not IDLE.
module apb_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT   // must be >= 2
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]        req_write,
   output logic [NUM_REQ-1:0]        req_gnt,
   output logic [NUM_REQ-1:0]        req_done,
   output logic                      req_err,
   output logic [DATA_W-1:0]         req_rdata,
   output logic                      PTRANSFER,
   output logic [ADDR_W-1:0]         ADDRESS,
   output logic                      WRITE_EN,
   output logic [DATA_W-1:0]         WRITE_DATA,
   input  logic                      xfer_done,
   input  logic [DATA_W-1:0]         READ_DATA,
   output logic                      busy
);

   localparam int IW    = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);
   // The counter starts at 0 on the first WAIT cycle; the cycle whose increment
   // would reach TIMEOUT-1 is the last one, so req_done lands TIMEOUT cycles after ISSUE.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

   arb_state_t          state_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]       last_q, last_d;
   logic [NUM_REQ-1:0]  gnt_q, done_q;
   logic                err_q, ptx_q, we_q, busy_q;
   logic [DATA_W-1:0]   rdata_q, wdata_q;
   logic [ADDR_W-1:0]   addr_q;

   logic [NUM_REQ-1:0]  elig, pick_gnt;
   logic                pick_vld;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic                we_d;

   // A requester completing this cycle still has req high; keep it out of the race.
   assign elig  = req & ~done_q;
   assign cnt_d = cnt_q + CNT_W'(1);

   rr_pick #(.N(NUM_REQ)) u_pick (
      .elig_i (elig),
      .last_i (last_q),
      .gnt_o  (pick_gnt),
      .vld_o  (pick_vld)
   );

   // Command fields of the freshly picked requester.
   always_comb begin
      addr_d  = '0;
      wdata_d = '0;
      we_d    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            addr_d  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_d = req_wdata[i*DATA_W +: DATA_W];
            we_d    = req_write[i];
         end
      end
   end

   // Index of the requester currently holding the grant.
   always_comb begin
      last_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) last_d = IW'(i);
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ptx_q   <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         // Completion outputs are single-cycle pulses.
         done_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  gnt_q   <= pick_gnt;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
                  we_q    <= we_d;
                  ptx_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               ptx_q   <= 1'b0;
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // A completion on the timeout cycle wins over the timeout.
               if (xfer_done || cnt_q == CNT_LAST) begin
                  done_q  <= gnt_q;
                  err_q   <= ~xfer_done;
                  rdata_q <= (xfer_done && !we_q) ? READ_DATA : '0;
                  last_q  <= last_d;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               ptx_q   <= 1'b0;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_gnt    = gnt_q;
   assign req_done   = done_q;
   assign req_err    = err_q;
   assign req_rdata  = rdata_q;
   assign PTRANSFER  = ptx_q;
   assign ADDRESS    = addr_q;
   assign WRITE_EN   = we_q;
   assign WRITE_DATA = wdata_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios, a transaction-level reference
// model compared every cycle, and literal expectations for each scenario.
module tb_apb_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic [N-1:0]      req;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      req_write;
   logic [N-1:0]      req_gnt, req_done;
   logic              req_err;
   logic [DW-1:0]     req_rdata;
   logic              PTRANSFER;
   logic [AW-1:0]     ADDRESS;
   logic              WRITE_EN;
   logic [DW-1:0]     WRITE_DATA;
   logic              xfer_done;
   logic [DW-1:0]     READ_DATA;
   logic              busy;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   apb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_write(req_write), .req_gnt(req_gnt),
      .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
      .PTRANSFER(PTRANSFER), .ADDRESS(ADDRESS), .WRITE_EN(WRITE_EN),
      .WRITE_DATA(WRITE_DATA), .xfer_done(xfer_done), .READ_DATA(READ_DATA),
      .busy(busy)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge PCLK);
   endtask

   // ---------------- reference model ----------------
   // Transaction view: an owner (or none) and the age of its transfer in cycles
   // since the PTRANSFER cycle. Age 0 is the issue cycle; completion is honoured
   // from age 1; with no completion the response appears TO cycles after issue.
   logic [N-1:0]  e_gnt = '0, e_done = '0, m_elig;
   logic          e_err = 1'b0, e_ptx = 1'b0, e_we = 1'b0, e_busy = 1'b0;
   logic [DW-1:0] e_rdata = '0, e_wdata = '0;
   logic [AW-1:0] e_addr = '0;
   int m_owner = -1, m_age = 0, m_last = N - 1, m_w;

   task automatic m_finish(input bit timed_out);
      e_done  = '0;
      e_done[m_owner] = 1'b1;
      e_err   = timed_out;
      e_rdata = (!timed_out && !e_we) ? READ_DATA : '0;
      m_last  = m_owner;
      m_owner = -1;
      e_gnt   = '0;
      e_busy  = 1'b0;
   endtask

   always @(posedge PCLK) begin
      if (PRESET) begin
         e_gnt = '0; e_done = '0; e_err = 1'b0; e_rdata = '0; e_ptx = 1'b0;
         e_addr = '0; e_we = 1'b0; e_wdata = '0; e_busy = 1'b0;
         m_owner = -1; m_age = 0; m_last = N - 1;
      end else begin
         m_elig  = req & ~e_done;
         e_done  = '0;
         e_err   = 1'b0;
         e_rdata = '0;
         if (m_owner < 0) begin
            m_w = -1;
            for (int k = 1; k <= N; k++)
               if (m_w < 0 && m_elig[(m_last + k) % N]) m_w = (m_last + k) % N;
            if (m_w >= 0) begin
               m_owner = m_w;
               m_age   = 0;
               e_gnt   = '0;
               e_gnt[m_w] = 1'b1;
               e_addr  = req_addr[m_w*AW +: AW];
               e_wdata = req_wdata[m_w*DW +: DW];
               e_we    = req_write[m_w];
               e_ptx   = 1'b1;
               e_busy  = 1'b1;
            end
         end else begin
            e_ptx = 1'b0;
            if (m_age >= 1 && xfer_done) m_finish(1'b0);
            else if (m_age == TO - 1)    m_finish(1'b1);
            else                         m_age++;
         end
      end
   end

   always @(negedge PCLK) begin
      if (cmp_en) begin
         chk("cyc_gnt",   req_gnt,    e_gnt);
         chk("cyc_done",  req_done,   e_done);
         chk("cyc_err",   req_err,    e_err);
         chk("cyc_rdata", req_rdata,  e_rdata);
         chk("cyc_ptx",   PTRANSFER,  e_ptx);
         chk("cyc_addr",  ADDRESS,    e_addr);
         chk("cyc_we",    WRITE_EN,   e_we);
         chk("cyc_wdata", WRITE_DATA, e_wdata);
         chk("cyc_busy",  busy,       e_busy);
      end
   end

   // ---------------- directed stimulus ----------------
   logic [N-1:0] got [5];
   int tmo;

   initial begin
      PRESET = 1'b1; req = '0; req_addr = '0; req_wdata = '0; req_write = '0;
      xfer_done = 1'b0; READ_DATA = '0;
      step(1);
      cmp_en = 1'b1;
      step(1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_gnt", req_gnt, 4'b0000);
      chk("rst_ptx", PTRANSFER, 1'b0);
      chk("rst_addr", ADDRESS, 32'h0);
      chk("rst_rdata", req_rdata, 32'h0);
      PRESET = 1'b0;
      step(1);

      // Single read from requester 2
      req = 4'b0100; req_addr[2*AW +: AW] = 32'h40;
      step(1);
      chk("rd_gnt", req_gnt, 4'b0100);
      chk("rd_ptx", PTRANSFER, 1'b1);
      chk("rd_addr", ADDRESS, 32'h40);
      chk("rd_we", WRITE_EN, 1'b0);
      req = '0; req_addr[2*AW +: AW] = 32'h99;
      step(2);
      xfer_done = 1'b1; READ_DATA = 32'hDEADBEEF;
      step(1);
      xfer_done = 1'b0;
      chk("rd_done", req_done, 4'b0100);
      chk("rd_rdata", req_rdata, 32'hDEADBEEF);
      chk("rd_err", req_err, 1'b0);
      chk("rd_addr_hold", ADDRESS, 32'h40);

      // Contention from reset
      PRESET = 1'b1;
      step(2);
      PRESET = 1'b0; req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tmo = 0;
         while (PTRANSFER !== 1'b1 && tmo < 20) begin step(1); tmo++; end
         chk("rr_wait", (tmo < 20), 1'b1);
         got[i] = req_gnt;
         step(1);
         xfer_done = 1'b1;
         if (i == 4) req = '0;
         step(1);
         xfer_done = 1'b0;
      end
      chk("rr_0", got[0], 4'b0001);
      chk("rr_1", got[1], 4'b0010);
      chk("rr_2", got[2], 4'b0100);
      chk("rr_3", got[3], 4'b1000);
      chk("rr_4", got[4], 4'b0001);

      // Write from requester 3
      req = 4'b1000; req_write = 4'b1000; req_wdata[3*DW +: DW] = 32'h12345678;
      step(1);
      chk("wr_gnt", req_gnt, 4'b1000);
      chk("wr_ptx", PTRANSFER, 1'b1);
      chk("wr_we", WRITE_EN, 1'b1);
      chk("wr_wdata", WRITE_DATA, 32'h12345678);
      req = '0;
      step(1);
      xfer_done = 1'b1; READ_DATA = 32'hCAFEF00D;
      step(1);
      xfer_done = 1'b0;
      chk("wr_done", req_done, 4'b1000);
      chk("wr_rdata", req_rdata, 32'h0);

      // Timeout on requester 1
      req = 4'b0010; req_write = '0; READ_DATA = 32'h55;
      step(1);
      chk("to_gnt", req_gnt, 4'b0010);
      req = '0;
      for (int i = 1; i <= 15; i++) step(1);
      chk("to_early", req_done, 4'b0000);
      step(1);
      chk("to_done", req_done, 4'b0010);
      chk("to_err", req_err, 1'b1);
      chk("to_rdata", req_rdata, 32'h0);
      step(1);
      chk("to_idle", busy, 1'b0);

      // Completion landing on the timeout cycle
      req = 4'b0010;
      step(1);
      req = '0;
      for (int i = 1; i <= 15; i++) step(1);
      xfer_done = 1'b1; READ_DATA = 32'hA5A5A5A5;
      step(1);
      xfer_done = 1'b0;
      chk("tc_done", req_done, 4'b0010);
      chk("tc_err", req_err, 1'b0);
      chk("tc_rdata", req_rdata, 32'hA5A5A5A5);

      // Held request after completion
      req = 4'b0001;
      step(2);
      xfer_done = 1'b1;
      step(1);
      xfer_done = 1'b0;
      chk("hold_done", req_done, 4'b0001);
      step(1);
      chk("hold_nogrant", req_gnt, 4'b0000);
      chk("hold_noptx", PTRANSFER, 1'b0);
      step(1);
      chk("hold_regrant", req_gnt, 4'b0001);
      chk("hold_ptx", PTRANSFER, 1'b1);
      req = '0;
      step(1);
      xfer_done = 1'b1;
      step(1);
      xfer_done = 1'b0;

      // Reset during WAIT
      req = 4'b0100;
      step(1);
      req = '0;
      step(2);
      PRESET = 1'b1; xfer_done = 1'b1;
      step(1);
      chk("mr_done", req_done, 4'b0000);
      chk("mr_gnt", req_gnt, 4'b0000);
      chk("mr_busy", busy, 1'b0);
      chk("mr_addr", ADDRESS, 32'h0);
      PRESET = 1'b0; xfer_done = 1'b0; req = 4'b1111;
      step(1);
      chk("mr_first", req_gnt, 4'b0001);
      req = '0;
      step(1);
      xfer_done = 1'b1;
      step(1);
      xfer_done = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t got no end expected finish", $time);
      $fatal(1);
   end

endmodule
